mc_control_unit: RTL and testbench

Parameterised multicycle control FSM for the RV32I core; the successor to the fixed four-state fetch controller. It drives the single-bus datapath (MAR, MDR, IR, PC, register file, ALU) through fetch, decode, execute, memory and writeback for all RV32I base classes. It adds a variable-latency memory handshake with timeout, store byte-enables, misalignment and illegal-opcode detection, and a halted/error status.

---
 rtl/mc_control_unit.sv | 181 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle RV32I control FSM for the single-bus datapath.
// Ports: clk/rst_n (sync, active-low); IR fields i_opcode/i_funct3/i_arithmatic/i_is_ebreak;
// datapath status i_addr_lsb/i_br_taken; memory handshake i_mem_resp;
// register loads o_load_*; bus/ALU/PC selects; memory strobes o_mem_read/o_mem_write
// with o_mem_byte_en; sticky status o_halted/o_err_code; o_state_dbg = current state.
module mc_control_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1,
  parameter int HALT_ON_EBREAK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_arithmatic,
  input  logic       i_is_ebreak,
  input  logic [1:0] i_addr_lsb,
  input  logic       i_br_taken,
  input  logic       i_mem_resp,
  output logic       o_load_mar,
  output logic       o_load_mdr,
  output logic       o_load_ir,
  output logic       o_load_pc,
  output logic       o_load_rd,
  output logic [1:0] o_pc_mux_sel,
  output logic [1:0] o_databus_mux_sel,
  output logic       o_alu_src_sel,
  output logic [3:0] o_alu_op,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic [3:0] o_mem_byte_en,
  output logic       o_halted,
  output logic [1:0] o_err_code,
  output logic [3:0] o_state_dbg
);
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, LOAD = 7'b0000011, STORE = 7'b0100011,
                         BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                         SYSTEM = 7'b1110011, MISC_MEM = 7'b0001111;

  // MEM_REQ is the cycle after MAR is loaded: the data access is only issued once
  // MAR holds the effective address, which gives loads 8 and stores 7 cycles.
  typedef enum logic [3:0] {
    S_FETCH_ADDR = 4'd0, S_FETCH_WAIT = 4'd1, S_FETCH_IR = 4'd2, S_DECODE = 4'd3,
    S_EXEC = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_REQ = 4'd6, S_MEM_WAIT = 4'd7,
    S_LOAD_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_HALT = 4'd11, S_ERROR = 4'd12
  } state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_cnt;
  logic [1:0]    r_err, w_err;
  logic [3:0]    r_be, w_be;
  logic          w_wait, w_timeout, w_misaligned, w_store;

  assign w_store      = i_opcode == STORE;
  assign w_wait       = r_state == S_FETCH_WAIT || r_state == S_MEM_WAIT;
  assign w_timeout    = TIMEOUT_CYCLES != 0 && r_cnt == TW'(TIMEOUT_CYCLES);
  // funct3[1:0]: 00 byte, 01 halfword, 1x word
  assign w_misaligned = (i_funct3[1:0] == 2'b01 && i_addr_lsb[0]) || (i_funct3[1] && i_addr_lsb != 2'b00);
  assign w_be         = i_funct3[1] ? 4'b1111 :
                        i_funct3[0] ? 4'b0011 << {i_addr_lsb[1], 1'b0} : 4'b0001 << i_addr_lsb;

  assign o_halted    = rst_n && r_state == S_HALT;
  assign o_err_code  = rst_n ? r_err : 2'd0;
  assign o_state_dbg = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH_ADDR;
      r_cnt   <= '0;
      r_err   <= 2'd0;
      r_be    <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_wait && !i_mem_resp) ? r_cnt + 1'b1 : '0;
      r_err   <= w_err;
      if (r_state == S_MEM_ADDR) r_be <= w_be;
    end
  end

  // Byte lanes are latched in MEM_ADDR so they stay stable while the ALU output moves on.
  always_comb begin
    w_next            = r_state;
    w_err             = r_err;
    o_load_mar        = 1'b0;
    o_load_mdr        = 1'b0;
    o_load_ir         = 1'b0;
    o_load_pc         = 1'b0;
    o_load_rd         = 1'b0;
    o_pc_mux_sel      = 2'd0;
    o_databus_mux_sel = 2'd0;
    o_alu_src_sel     = 1'b0;
    o_alu_op          = 4'd0;
    o_mem_read        = 1'b0;
    o_mem_write       = 1'b0;
    o_mem_byte_en     = 4'd0;
    if (rst_n) begin
      case (r_state)
        S_FETCH_ADDR: begin
          o_load_mar = 1'b1;
          o_load_pc  = 1'b1;
          o_mem_read = 1'b1;
          w_next     = S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          o_mem_read = 1'b1;
          o_load_mdr = i_mem_resp;
          w_next     = i_mem_resp ? S_FETCH_IR : w_timeout ? S_ERROR : S_FETCH_WAIT;
          w_err      = (!i_mem_resp && w_timeout) ? 2'd1 : r_err;
        end
        S_FETCH_IR: begin
          o_databus_mux_sel = 2'd1;
          o_load_ir         = 1'b1;
          w_next            = S_DECODE;
        end
        S_DECODE: begin
          case (i_opcode)
            OP, OP_IMM, LUI, AUIPC: w_next = S_EXEC;
            LOAD, STORE:            w_next = S_MEM_ADDR;
            BRANCH:                 w_next = S_BRANCH;
            JAL, JALR:              w_next = S_JUMP;
            SYSTEM:                 w_next = (i_is_ebreak && HALT_ON_EBREAK != 0) ? S_HALT : S_FETCH_ADDR;
            MISC_MEM:               w_next = S_FETCH_ADDR;
            default: begin
              w_next = S_ERROR;
              w_err  = 2'd2;
            end
          endcase
        end
        S_EXEC: begin
          o_load_rd         = 1'b1;
          o_databus_mux_sel = i_opcode == LUI ? 2'd3 : 2'd2;
          o_alu_src_sel     = i_opcode != OP;
          // funct7[5] only qualifies OP and the OP-IMM shifts (SLLI/SRLI/SRAI)
          o_alu_op          = (i_opcode == OP || (i_opcode == OP_IMM && i_funct3[1:0] == 2'b01)) ? {i_arithmatic, i_funct3} :
                              i_opcode == OP_IMM ? {1'b0, i_funct3} : 4'd0;
          w_next            = S_FETCH_ADDR;
        end
        S_MEM_ADDR: begin
          o_alu_src_sel     = 1'b1;
          o_databus_mux_sel = 2'd2;
          o_load_mar        = 1'b1;
          w_next            = w_misaligned ? S_ERROR : S_MEM_REQ;
          w_err             = w_misaligned ? 2'd3 : r_err;
        end
        S_MEM_REQ: begin
          o_mem_read    = !w_store;
          o_mem_write   = w_store;
          o_mem_byte_en = w_store ? r_be : 4'd0;
          w_next        = S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          o_mem_read    = !w_store;
          o_mem_write   = w_store;
          o_mem_byte_en = w_store ? r_be : 4'd0;
          o_load_mdr    = i_mem_resp && !w_store;
          w_next        = i_mem_resp ? (w_store ? S_FETCH_ADDR : S_LOAD_WB) : w_timeout ? S_ERROR : S_MEM_WAIT;
          w_err         = (!i_mem_resp && w_timeout) ? 2'd1 : r_err;
        end
        S_LOAD_WB: begin
          o_databus_mux_sel = 2'd1;
          o_load_rd         = 1'b1;
          w_next            = S_FETCH_ADDR;
        end
        S_BRANCH: begin
          o_load_pc    = i_br_taken;
          o_pc_mux_sel = i_br_taken ? 2'd1 : 2'd0;
          w_next       = S_FETCH_ADDR;
        end
        S_JUMP: begin
          o_load_rd    = 1'b1;
          o_load_pc    = 1'b1;
          o_pc_mux_sel = i_opcode == JAL ? 2'd1 : 2'd2;
          w_next       = S_FETCH_ADDR;
        end
        S_HALT, S_ERROR: w_next = r_state;
        default: w_next = S_FETCH_ADDR;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: per-cycle output trace checks of mc_control_unit against an instruction-level model.
module tb_mc_control_unit;
  localparam int T = 4;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, SYS = 7'b1110011, FEN = 7'b0001111;

  typedef struct packed {
    logic mar, mdr, ir, pc, rd;
    logic [1:0] pcs, dbs;
    logic src;
    logic [3:0] op;
    logic rds, wrs;
    logic [3:0] be;
    logic hlt;
    logic [1:0] err;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic i_arithmatic = 1'b0, i_is_ebreak = 1'b0, i_br_taken = 1'b0, i_mem_resp = 1'b0;
  logic [1:0] i_addr_lsb = '0;
  logic o_load_mar, o_load_mdr, o_load_ir, o_load_pc, o_load_rd, o_alu_src_sel;
  logic o_mem_read, o_mem_write, o_halted;
  logic [1:0] o_pc_mux_sel, o_databus_mux_sel, o_err_code;
  logic [3:0] o_alu_op, o_mem_byte_en, o_state_dbg;
  vec_t got;
  int total = 0, bad = 0, cyc = 0, abort_at = -1;
  bit dead = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.TIMEOUT_CYCLES(T), .HALT_ON_EBREAK(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_arithmatic(i_arithmatic), .i_is_ebreak(i_is_ebreak), .i_addr_lsb(i_addr_lsb),
    .i_br_taken(i_br_taken), .i_mem_resp(i_mem_resp),
    .o_load_mar(o_load_mar), .o_load_mdr(o_load_mdr), .o_load_ir(o_load_ir),
    .o_load_pc(o_load_pc), .o_load_rd(o_load_rd), .o_pc_mux_sel(o_pc_mux_sel),
    .o_databus_mux_sel(o_databus_mux_sel), .o_alu_src_sel(o_alu_src_sel), .o_alu_op(o_alu_op),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_byte_en(o_mem_byte_en),
    .o_halted(o_halted), .o_err_code(o_err_code), .o_state_dbg(o_state_dbg)
  );

  assign got = {o_load_mar, o_load_mdr, o_load_ir, o_load_pc, o_load_rd, o_pc_mux_sel,
                o_databus_mux_sel, o_alu_src_sel, o_alu_op, o_mem_read, o_mem_write,
                o_mem_byte_en, o_halted, o_err_code};

  task automatic do_reset();
    rst_n = 1'b0;
    i_mem_resp = 1'($urandom);
    @(negedge clk);
    total++;
    assert (got === vec_t'(0)) else begin
      bad++;
      $error("FAIL reset_idle got=%h exp=%h", got, vec_t'(0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(input string tag, input vec_t exp, input logic resp);
    if (dead) return;
    cyc++;
    if (cyc == abort_at) begin
      dead = 1;
      do_reset();
      return;
    end
    i_mem_resp = resp;
    @(negedge clk);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s op=%b cyc=%0d got=%h exp=%h", tag, i_opcode, cyc, got, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // A wait phase: response arrives after d idle cycles, unless the idle count reaches T first.
  task automatic wait_mem(input string tag, input vec_t base, input bit mdr_on, input int d, output bit to);
    to = 0;
    for (int k = 0; ; k++) begin
      vec_t e = base;
      bit r = (k == d);
      e.mdr = r & mdr_on;
      step(tag, e, r);
      if (r) break;
      if (k == T) begin
        to = 1;
        break;
      end
    end
  endtask

  task automatic term(input bit hlt, input logic [1:0] err);
    vec_t e = '0;
    e.hlt = hlt;
    e.err = err;
    repeat (3) step(hlt ? "halt_idle" : "error_idle", e, 1'($urandom));
    if (!dead) do_reset();
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic ar, eb,
                     input logic [1:0] lsb, input logic br, input int fd, md);
    vec_t e;
    bit to;
    int bytes;
    i_opcode = op; i_funct3 = f3; i_arithmatic = ar; i_is_ebreak = eb;
    i_addr_lsb = lsb; i_br_taken = br;
    cyc = 0;
    dead = 0;
    e = '0; e.mar = 1; e.pc = 1; e.rds = 1;
    step("fetch_addr", e, 1'($urandom));
    e = '0; e.rds = 1;
    wait_mem("fetch_wait", e, 1, fd, to);
    if (to) begin
      term(0, 2'd1);
      return;
    end
    e = '0; e.dbs = 2'd1; e.ir = 1;
    step("fetch_ir", e, 1'($urandom));
    e = '0;
    step("decode", e, 1'($urandom));
    if (op == OP || op == OPI || op == LUI || op == AUIPC) begin
      e.rd = 1;
      e.dbs = op == LUI ? 2'd3 : 2'd2;
      e.src = op != OP;
      if (op == OP || (op == OPI && (f3 == 3'b001 || f3 == 3'b101))) e.op = {ar, f3};
      else if (op == OPI) e.op = {1'b0, f3};
      step("exec", e, 1'($urandom));
    end else if (op == LD || op == ST) begin
      bytes = 1 << f3[1:0];
      e.src = 1; e.dbs = 2'd2; e.mar = 1;
      step("mem_addr", e, 1'($urandom));
      if (int'(lsb) % bytes != 0) begin
        term(0, 2'd3);
        return;
      end
      e = '0;
      e.rds = op == LD;
      e.wrs = op == ST;
      e.be = op == ST ? (4'((1 << bytes) - 1) << lsb) : 4'b0;
      step("mem_req", e, 1'($urandom));
      wait_mem("mem_wait", e, op == LD, md, to);
      if (to) begin
        term(0, 2'd1);
        return;
      end
      if (op == LD) begin
        e = '0; e.dbs = 2'd1; e.rd = 1;
        step("load_wb", e, 1'($urandom));
      end
    end else if (op == BR) begin
      e.pc = br;
      e.pcs = br ? 2'd1 : 2'd0;
      step("branch", e, 1'($urandom));
    end else if (op == JAL || op == JALR) begin
      e.rd = 1; e.pc = 1;
      e.pcs = op == JAL ? 2'd1 : 2'd2;
      step("jump", e, 1'($urandom));
    end else if (op == SYS) begin
      if (eb) term(1, 2'd0);
    end else if (op != FEN) begin
      term(0, 2'd2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [12];
    logic [6:0] op;
    logic [2:0] f3;
    ops = '{OP, OPI, LUI, AUIPC, LD, ST, BR, JAL, JALR, SYS, FEN, 7'b1011011};
    @(posedge clk);
    #1 do_reset();
    run(OP, 3'b000, 0, 0, 2'd0, 0, 0, 0);
    run(LD, 3'b010, 0, 0, 2'd0, 0, 2, 2);
    run(ST, 3'b000, 0, 0, 2'd2, 0, 0, 1);
    run(ST, 3'b001, 0, 0, 2'd1, 0, 0, 0);
    run(ST, 3'b001, 0, 0, 2'd2, 0, 1, 0);
    run(LD, 3'b010, 0, 0, 2'd2, 0, 0, 0);
    run(OP, 3'b000, 1, 0, 2'd0, 0, 9, 0);
    run(BR, 3'b000, 0, 0, 2'd0, 1, 0, 0);
    run(BR, 3'b000, 0, 0, 2'd0, 0, 0, 0);
    run(JALR, 3'b000, 0, 0, 2'd0, 0, 0, 0);
    run(JAL, 3'b000, 0, 0, 2'd0, 0, 3, 0);
    run(LUI, 3'b000, 0, 0, 2'd0, 0, 0, 0);
    run(OPI, 3'b101, 1, 0, 2'd0, 0, 0, 0);
    run(OPI, 3'b000, 1, 0, 2'd0, 0, 4, 0);
    run(SYS, 3'b000, 0, 1, 2'd0, 0, 0, 0);
    run(7'b0000000, 3'b000, 0, 0, 2'd0, 0, 0, 0);
    run(ST, 3'b010, 0, 0, 2'd0, 0, 0, 9);
    abort_at = 8;
    run(LD, 3'b010, 0, 0, 2'd0, 0, 0, 3);
    abort_at = -1;
    run(OP, 3'b111, 0, 0, 2'd0, 0, 0, 0);
    run(FEN, 3'b000, 0, 1, 2'd0, 0, 0, 0);
    run(SYS, 3'b000, 0, 0, 2'd0, 0, 0, 0);
    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 11)];
      f3 = 3'($urandom);
      if (op == LD || op == ST) f3 = 3'($urandom_range(0, 2)) | ((op == LD && $urandom_range(0, 1) == 1) ? 3'b100 : 3'b000);
      run(op, f3, 1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom),
          $urandom_range(0, 5), $urandom_range(0, 5));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
